// File: rtl/framing_pkg.sv
// Shared framing constants and the framer FSM state encoding.
package framing_pkg;

    localparam int unsigned HEADER_BYTE0 = 32'h0000_00A5;
    localparam int unsigned HEADER_BYTE1 = 32'h0000_005A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER0 = 2'd1,
        ST_HEADER1 = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_e;

endpackage

// File: rtl/counter.sv
// Generic up-counter with synchronous clear; clear wins over increment.
module counter #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] r_count;

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (clr_i) begin
            r_count <= '0;
        end else if (inc_i) begin
            r_count <= r_count + Width'(1'b1);
        end else begin
            r_count <= r_count;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/packer.sv
// Packs PackedNum elements LSB-first into one word held in an output register.
module packer #(
    parameter int UnpackedWidth = 1,
    parameter int PackedNum     = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [UnpackedWidth-1:0]             in_data_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [UnpackedWidth*PackedNum-1:0]   out_data_o
);

    localparam int PackedWidth = UnpackedWidth * PackedNum;
    localparam int CntW        = (PackedNum > 1) ? $clog2(PackedNum) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(PackedNum - 1);

    logic [CntW-1:0]        r_cnt;
    logic [PackedWidth-1:0] r_acc;
    logic [PackedWidth-1:0] r_out_data;
    logic                   r_out_valid;
    logic [PackedWidth-1:0] w_acc_next;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_word_done;

    // Only the word-completing element needs the output register to be free (or draining).
    assign in_ready_o  = (r_cnt != LastIdx) || !r_out_valid || out_ready_i;
    assign w_in_fire   = in_valid_i && in_ready_o;
    assign w_out_fire  = r_out_valid && out_ready_i;
    assign w_word_done = w_in_fire && (r_cnt == LastIdx);

    // Accumulator with the incoming element dropped into its slot
    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[int'(r_cnt) * UnpackedWidth +: UnpackedWidth] = in_data_i;
    end

    // Accumulator, slot index and output register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_word_done) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_in_fire) begin
                r_cnt <= r_cnt + CntW'(1'b1);
                r_acc <= w_acc_next;
            end else begin
                r_cnt <= r_cnt;
                r_acc <= r_acc;
            end

            if (w_word_done) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_data  <= '0;
            end else begin
                r_out_valid <= r_out_valid;
                r_out_data  <= r_out_data;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;

endmodule

// File: rtl/framer.sv
// Frames a stream of narrow elements into packets: two header words then
// PacketLenBytes packed payload words.
module framer
    import framing_pkg::*;
#(
    parameter int          UnpackedWidth  = 1,
    parameter int          PackedNum      = 8,
    parameter int          PacketLenBytes = 1024,
    parameter int unsigned HeaderByte0    = HEADER_BYTE0,
    parameter int unsigned HeaderByte1    = HEADER_BYTE1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [UnpackedWidth-1:0]           unpacked_i,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [UnpackedWidth*PackedNum-1:0] data_o
);

    localparam int PackedWidth = UnpackedWidth * PackedNum;
    localparam int WordCntW    = $clog2(PacketLenBytes + 1);
    localparam int ElemCntW    = $clog2(PacketLenBytes * PackedNum + 1);
    localparam logic [WordCntW-1:0]    LastWord = WordCntW'(PacketLenBytes - 1);
    localparam logic [ElemCntW-1:0]    LastElem = ElemCntW'(PacketLenBytes * PackedNum - 1);
    localparam logic [PackedWidth-1:0] Hdr0     = PackedWidth'(HeaderByte0);
    localparam logic [PackedWidth-1:0] Hdr1     = PackedWidth'(HeaderByte1);

    state_e                 r_state;
    state_e                 w_state_next;
    logic                   r_in_done;
    logic                   w_pk_in_valid;
    logic                   w_pk_in_ready;
    logic                   w_pk_out_valid;
    logic                   w_pk_out_ready;
    logic [PackedWidth-1:0] w_pk_data;
    logic                   w_in_fire;
    logic                   w_pl_fire;
    logic                   w_last_elem;
    logic                   w_last_word;
    logic [WordCntW-1:0]    w_word_cnt;
    logic [ElemCntW-1:0]    w_elem_cnt;

    assign w_in_fire      = valid_i && ready_o;
    assign w_last_elem    = w_in_fire && (w_elem_cnt == LastElem);
    assign w_pl_fire      = (r_state == ST_PAYLOAD) && w_pk_out_valid && ready_i;
    assign w_last_word    = w_pl_fire && (w_word_cnt == LastWord);
    assign w_pk_in_valid  = valid_i && (r_state == ST_PAYLOAD) && !r_in_done;
    assign w_pk_out_ready = ready_i && (r_state == ST_PAYLOAD);

    packer #(
        .UnpackedWidth (UnpackedWidth),
        .PackedNum     (PackedNum)
    ) u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (w_pk_in_valid),
        .in_ready_o  (w_pk_in_ready),
        .in_data_i   (unpacked_i),
        .out_valid_o (w_pk_out_valid),
        .out_ready_i (w_pk_out_ready),
        .out_data_o  (w_pk_data)
    );

    counter #(.Width(WordCntW)) u_word_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_last_word),
        .inc_i   (w_pl_fire),
        .count_o (w_word_cnt)
    );

    counter #(.Width(ElemCntW)) u_elem_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_last_elem),
        .inc_i   (w_in_fire),
        .count_o (w_elem_cnt)
    );

    // Input side closes once the packet's final element is in; reopens after its last word leaves
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in_done <= 1'b0;
        end else if (w_last_elem) begin
            r_in_done <= 1'b1;
        end else if (w_last_word) begin
            r_in_done <= 1'b0;
        end else begin
            r_in_done <= r_in_done;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) w_state_next = ST_HEADER0;
                else         w_state_next = ST_IDLE;
            end
            ST_HEADER0: begin
                if (ready_i) w_state_next = ST_HEADER1;
                else         w_state_next = ST_HEADER0;
            end
            ST_HEADER1: begin
                if (ready_i) w_state_next = ST_PAYLOAD;
                else         w_state_next = ST_HEADER1;
            end
            ST_PAYLOAD: begin
                if (w_last_word) w_state_next = ST_IDLE;
                else             w_state_next = ST_PAYLOAD;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode; the packer keeps its data at zero while it holds no word
    always_comb begin
        valid_o = 1'b0;
        ready_o = 1'b0;
        data_o  = '0;
        case (r_state)
            ST_IDLE: begin
                valid_o = 1'b0;
                ready_o = 1'b0;
                data_o  = '0;
            end
            ST_HEADER0: begin
                valid_o = 1'b1;
                data_o  = Hdr0;
            end
            ST_HEADER1: begin
                valid_o = 1'b1;
                data_o  = Hdr1;
            end
            ST_PAYLOAD: begin
                valid_o = w_pk_out_valid;
                ready_o = w_pk_in_ready && !r_in_done;
                data_o  = w_pk_data;
            end
            default: begin
                valid_o = 1'b0;
                ready_o = 1'b0;
                data_o  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_framer.sv
// Scoreboard bench for framer: random and directed packets against a packet-level model.
module tb_framer;

    localparam int UW  = 2;
    localparam int PN  = 4;
    localparam int PLB = 4;
    localparam int PW  = UW * PN;
    localparam int EPP = PN * PLB;

    logic          clk_i      = 1'b0;
    logic          rst_i      = 1'b1;
    logic          valid_i    = 1'b0;
    logic          ready_i    = 1'b1;
    logic [UW-1:0] unpacked_i = '0;
    logic          ready_o;
    logic          valid_o;
    logic [PW-1:0] data_o;

    framer #(
        .UnpackedWidth  (UW),
        .PackedNum      (PN),
        .PacketLenBytes (PLB)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .unpacked_i (unpacked_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_checks   = 0;
    int            n_pass     = 0;
    logic [PW-1:0] exp_q[$];
    int            acc_cnt    = 0;
    int            out_idx    = 0;
    int            h1_hold    = 0;
    int            ready_mode = 0;
    int            stall_left = 0;
    bit            prev_stall = 1'b0;
    logic [PW-1:0] prev_data  = '0;
    bit            abort      = 1'b0;
    logic [UW-1:0] pkt[EPP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    endtask

    // Ready generator: always ready, random back-pressure, or a single 3-cycle stall on header 1
    always @(posedge clk_i) begin
        #1;
        case (ready_mode)
            0: ready_i = 1'b1;
            1: ready_i = ($urandom_range(0, 3) != 0);
            default: begin
                if (valid_o && data_o == 8'h5A && stall_left > 0) begin
                    ready_i = 1'b0;
                    stall_left--;
                end else begin
                    ready_i = 1'b1;
                end
            end
        endcase
    end

    // Monitor: pop and compare on every out-fire, plus handshake rules
    always @(negedge clk_i) begin
        logic [PW-1:0] e;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(valid_o), 32'd1);
                chk("hold_data", 32'(data_o), 32'(prev_data));
            end
            if (!valid_o) chk("idle_data_zero", 32'(data_o), 32'd0);
            if (ready_o) chk("ready_window", 32'(out_idx >= 2 && acc_cnt < EPP), 32'd1);
            if (valid_i && ready_o) acc_cnt++;
            if (valid_o && !ready_i && out_idx == 1) h1_hold++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 32'(data_o), 32'(e));
                end
                out_idx++;
                if (out_idx == PLB + 2) begin
                    out_idx = 0;
                    acc_cnt = 0;
                end
            end
            prev_stall = valid_o && !ready_i;
            prev_data  = data_o;
        end
    end

    // Reference: headers, then each word is the weighted sum of its elements, first element lowest
    task automatic push_expected(input int nwords);
        exp_q.push_back(PW'(8'hA5));
        exp_q.push_back(PW'(8'h5A));
        for (int w = 0; w < nwords; w++) begin
            int word = 0;
            for (int i = 0; i < PN; i++) word += int'(pkt[w*PN + i]) * (1 << (UW * i));
            exp_q.push_back(PW'(word));
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < EPP; k++) pkt[k] = UW'($urandom_range(0, (1 << UW) - 1));
    endtask

    task automatic drive_pkt(input int n, input int gap_max);
        for (int k = 0; k < n; k++) begin
            int budget = 0;
            bit acc    = 1'b0;
            if (abort) break;
            valid_i    = 1'b1;
            unpacked_i = pkt[k];
            while (!acc && budget < 400) begin
                @(negedge clk_i);
                acc = ready_o;
                @(posedge clk_i);
                #1;
                budget++;
            end
            if (!acc) begin
                chk("accept_timeout", 32'd0, 32'd1);
                abort = 1'b1;
            end
            if (gap_max > 0) begin
                int g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    valid_i = 1'b0;
                    repeat (g) @(posedge clk_i);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 600) begin
            @(posedge clk_i);
            budget++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Idle with no input
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            chk("idle_valid_o", 32'(valid_o), 32'd0);
            chk("idle_ready_o", 32'(ready_o), 32'd0);
        end
        @(posedge clk_i);
        #1;

        // Fixed pattern 0,1,2,3 repeated
        for (int k = 0; k < EPP; k++) pkt[k] = UW'(k % 4);
        push_expected(PLB);
        drive_pkt(EPP, 0);
        valid_i = 1'b0;
        drain();
        @(negedge clk_i);
        chk("post_pkt_valid", 32'(valid_o), 32'd0);

        // Header 1 stalled for three cycles
        ready_mode = 2;
        stall_left = 3;
        h1_hold    = 0;
        fill_random();
        push_expected(PLB);
        drive_pkt(EPP, 1);
        valid_i = 1'b0;
        drain();
        chk("h1_hold_cycles", 32'(h1_hold), 32'd3);
        ready_mode = 0;

        // Payload words equal to a header pass unescaped
        for (int k = 0; k < EPP; k++) pkt[k] = UW'((k % 4) < 2 ? 1 : 2);
        push_expected(PLB);
        drive_pkt(EPP, 0);
        valid_i = 1'b0;
        drain();
        chk("pkt_boundary", 32'(out_idx), 32'd0);

        // Two packets back to back with valid_i held high
        for (int p = 0; p < 2; p++) begin
            fill_random();
            push_expected(PLB);
            drive_pkt(EPP, 0);
        end
        valid_i = 1'b0;
        drain();
        @(negedge clk_i);
        chk("post_b2b_valid", 32'(valid_o), 32'd0);

        // Random gaps and back-pressure
        ready_mode = 1;
        for (int p = 0; p < 6; p++) begin
            fill_random();
            push_expected(PLB);
            drive_pkt(EPP, 3);
        end
        valid_i = 1'b0;
        drain();
        ready_mode = 0;

        // Reset after two payload words with a partial word in the packer
        fill_random();
        push_expected(2);
        drive_pkt(10, 0);
        valid_i = 1'b0;
        drain();
        @(posedge clk_i);
        #1;
        rst_i   = 1'b1;
        exp_q.delete();
        acc_cnt = 0;
        out_idx = 0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        @(posedge clk_i);
        #1;

        // Fresh packet after the reset
        fill_random();
        push_expected(PLB);
        drive_pkt(EPP, 1);
        valid_i = 1'b0;
        drain();
        @(negedge clk_i);
        chk("final_valid", 32'(valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
